// File: rtl/csel_pkg.sv
// Shared constants and sizing helpers for the pipelined carry-select adder.
package csel_pkg;

    localparam int DEF_SEG_W = 4;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int num_seg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

    function automatic int num_stg(input int width, input int seg_w, input int segs_per_stg);
        return ceil_div(width / seg_w, segs_per_stg);
    endfunction

endpackage

// File: rtl/csel_segment.sv
// One carry-select segment: two lookahead carry chains (cin=0 and cin=1) and a select mux.
module csel_segment
    import csel_pkg::*;
#(
    parameter int SEG_W = DEF_SEG_W
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] seg_sum,
    output logic             seg_cout,
    output logic             seg_c_msb
);

    logic [SEG_W-1:0] g;
    logic [SEG_W-1:0] p;
    logic [SEG_W:0]   c0;
    logic [SEG_W:0]   c1;
    logic             gen;
    logic             prp;

    assign g = a & b;
    assign p = a ^ b;

    // Sum-of-products lookahead: carry i+1 = G[i:0], plus P[i:0] when the carry-in is 1.
    always_comb begin
        c0    = '0;
        c1    = '0;
        c1[0] = 1'b1;
        gen   = 1'b0;
        prp   = 1'b0;
        for (int i = 0; i < SEG_W; i++) begin
            gen = g[i];
            prp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                gen = gen | (prp & g[j]);
                prp = prp & p[j];
            end
            c0[i+1] = gen;
            c1[i+1] = gen | prp;
        end
    end

    assign seg_sum   = cin ? (p ^ c1[SEG_W-1:0]) : (p ^ c0[SEG_W-1:0]);
    assign seg_cout  = cin ? c1[SEG_W] : c0[SEG_W];
    assign seg_c_msb = cin ? c1[SEG_W-1] : c0[SEG_W-1];

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready backpressure.
// Define CSEL_SAT_EN to saturate the result on signed overflow.
module pipelined_csel_adder
    import csel_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int SEG_W        = DEF_SEG_W,
    parameter int SEGS_PER_STG = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSEG   = num_seg(WIDTH, SEG_W);
    localparam int NSTG   = num_stg(WIDTH, SEG_W, SEGS_PER_STG);
    localparam int GRP_W  = SEGS_PER_STG * SEG_W;
    localparam int PAD_W  = NSTG * GRP_W;
    localparam int LAST_J = (NSEG - 1) - (NSTG - 1) * SEGS_PER_STG;

    if ((WIDTH % SEG_W) != 0 || SEGS_PER_STG < 1) begin : g_bad_cfg
        $error("pipelined_csel_adder: WIDTH must be a multiple of SEG_W and SEGS_PER_STG >= 1");
    end

    // Handshake: valid/ready transfer when both are high; the whole pipe moves only when
    // the output slot is empty or being drained, so in_ready mirrors that advance condition.
    logic             adv;
    logic [PAD_W-1:0] a_pad;
    logic [PAD_W-1:0] b_pad;

    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;
    assign a_pad    = PAD_W'(a);
    assign b_pad    = PAD_W'(b ^ {WIDTH{sub}});

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int LO     = k * GRP_W;
        localparam int REM_IN = PAD_W - LO;

        logic [REM_IN-1:0]       a_in;
        logic [REM_IN-1:0]       b_in;
        logic                    c_in;
        logic                    v_in;
        logic [GRP_W-1:0]        grp_sum;
        logic [SEGS_PER_STG:0]   chain;
        logic [SEGS_PER_STG-1:0] cmsb;
        logic [LO+GRP_W-1:0]     s_raw;
        logic [LO+GRP_W-1:0]     s_d;
        logic [LO+GRP_W-1:0]     s_q;
        logic                    v_q;
        logic                    c_q;

        if (k == 0) begin : g_src
            assign a_in  = a_pad;
            assign b_in  = b_pad;
            assign c_in  = cin | sub;
            assign v_in  = in_valid;
            assign s_raw = grp_sum;
        end else begin : g_src
            assign a_in  = g_stg[k-1].g_rem.a_q;
            assign b_in  = g_stg[k-1].g_rem.b_q;
            assign c_in  = g_stg[k-1].c_q;
            assign v_in  = g_stg[k-1].v_q;
            assign s_raw = {grp_sum, g_stg[k-1].s_q};
        end

        assign chain[0] = c_in;
        for (genvar j = 0; j < SEGS_PER_STG; j++) begin : g_seg
            if (k * SEGS_PER_STG + j < NSEG) begin : g_real
                csel_segment #(.SEG_W(SEG_W)) u_seg (
                    .a         (a_in[j*SEG_W +: SEG_W]),
                    .b         (b_in[j*SEG_W +: SEG_W]),
                    .cin       (chain[j]),
                    .seg_sum   (grp_sum[j*SEG_W +: SEG_W]),
                    .seg_cout  (chain[j+1]),
                    .seg_c_msb (cmsb[j])
                );
            end else begin : g_pad
                // Partial last group: carry passes straight through empty slots.
                assign grp_sum[j*SEG_W +: SEG_W] = '0;
                assign chain[j+1]                = chain[j];
                assign cmsb[j]                   = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_in;
                c_q <= chain[SEGS_PER_STG];
                s_q <= s_d;
            end
        end

        if (k < NSTG - 1) begin : g_rem
            logic [REM_IN-GRP_W-1:0] a_q;
            logic [REM_IN-GRP_W-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_in[REM_IN-1:GRP_W];
                    b_q <= b_in[REM_IN-1:GRP_W];
                end
            end
            assign s_d = s_raw;
        end else begin : g_tail
            logic ovf_d;
            logic ovf_q;

            assign ovf_d = cmsb[LAST_J] ^ chain[SEGS_PER_STG];
`ifdef CSEL_SAT_EN
            logic [WIDTH-1:0] sat_val;
            // Saturate toward a's sign; cout/ovf keep reporting the raw result.
            assign sat_val = a_in[WIDTH-1-LO] ? {1'b1, {(WIDTH-1){1'b0}}}
                                              : {1'b0, {(WIDTH-1){1'b1}}};
            assign s_d     = ovf_d ? PAD_W'(sat_val) : s_raw;
`else
            assign s_d = s_raw;
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= ovf_d;
                end
            end

            assign out_valid = v_q;
            assign sum       = s_q[WIDTH-1:0];
            assign cout      = c_q;
            assign ovf       = ovf_q;
        end
    end

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Directed bench for pipelined_csel_adder (WIDTH=32, SEG_W=4, SEGS_PER_STG=2, latency 4).
module tb_pipelined_csel_adder;

    localparam int W    = 35;
    localparam int NSTG = 4;
    localparam int NBEAT = 20;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    int checks;
    int errors;
    logic [W-1:0] exp_q[$];

    pipelined_csel_adder #(
        .WIDTH        (32),
        .SEG_W        (4),
        .SEGS_PER_STG (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: {valid, ovf, cout, sum}
    function automatic logic [W-1:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                           input logic mc, input logic ms);
        logic [31:0] be;
        logic [32:0] r;
        logic [31:0] s;
        logic        o;
        be = ms ? ~mb : mb;
        r  = {1'b0, ma} + {1'b0, be} + {32'd0, (ms | mc)};
        o  = (ma[31] == be[31]) && (r[31] != ma[31]);
        s  = r[31:0];
`ifdef CSEL_SAT_EN
        if (o) s = ma[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {1'b1, o, r[32], s};
    endfunction

    task automatic drive_beat(input int i);
        logic [31:0] x;
        x   = 32'h9E37_79B9 * 32'(i + 1);
        a   = x;
        b   = 32'h7F4A_7C15 ^ (x << 3);
        cin = i[0];
        sub = (i % 3 == 0);
    endtask

    // Single beat with out_ready held high; checks latency and all result fields.
    task automatic run_single(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                              input logic tc, input logic ts, input logic [31:0] es,
                              input logic ec, input logic eo);
        int lat;
        a = ta; b = tbv; cin = tc; sub = ts;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(NSTG));
        chk({tag, "_sum"}, 64'(sum), 64'(es));
        chk({tag, "_cout"}, 64'(cout), 64'(ec));
        chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
        @(posedge clk); #1;
    endtask

    logic [31:0] rdy_pat;
    logic [W-1:0] held_val;
    logic [W-1:0] expv;
    logic        held;
    logic        fire_in;
    int          idx;
    int          got;
    int          extra;
    int          qsz;

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout_ovf", 64'({cout, ovf}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed arithmetic vectors
        run_single("add_5_7_c1", 32'd5, 32'd7, 1'b1, 1'b0, 32'd13, 1'b0, 1'b0);
        run_single("allones_p1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
`ifdef CSEL_SAT_EN
        run_single("maxpos_p1", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        run_single("minneg_x2", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
        run_single("sub_min_1", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1);
`else
        run_single("maxpos_p1", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_single("minneg_x2", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
        run_single("sub_min_1", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
`endif
        run_single("sub_eq", 32'd10, 32'd10, 1'b0, 1'b1, 32'd0, 1'b1, 1'b0);
        run_single("sub_3_5", 32'd3, 32'd5, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_single("sub_cin_ign", 32'd10, 32'd3, 1'b0, 1'b1, 32'd7, 1'b1, 1'b0);
        run_single("carry_span", 32'h0000_FFFF, 32'd1, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
        run_single("carry_top", 32'h0FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h1000_0001, 1'b0, 1'b0);

        // Stream with backpressure: fixed ready pattern including long stalls
        rdy_pat = 32'b1101_0000_0011_1011_0000_0000_1110_0101;
        idx = 0; got = 0; held = 1'b0; held_val = '0;
        for (int cyc = 0; cyc < 300 && got < NBEAT; cyc++) begin
            out_ready = rdy_pat[cyc % 32];
            if (idx < NBEAT) begin
                drive_beat(idx);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk("in_ready_rule", 64'(in_ready), 64'(!out_valid | out_ready));
            if (held) chk("held_stable", 64'({out_valid, ovf, cout, sum}), 64'(held_val));
            if (out_valid && out_ready) begin
                qsz = exp_q.size();
                if (qsz == 0) begin
                    chk("unexpected_beat", 64'(qsz), 64'd1);
                end else begin
                    expv = exp_q.pop_front();
                    chk("stream_result", 64'({out_valid, ovf, cout, sum}), 64'(expv));
                end
                got++;
            end
            held     = out_valid & !out_ready;
            held_val = {out_valid, ovf, cout, sum};
            fire_in  = in_valid & in_ready;
            @(posedge clk); #1;
            if (fire_in) begin
                exp_q.push_back(model(a, b, cin, sub));
                idx++;
            end
        end
        chk("stream_count", 64'(got), 64'(NBEAT));
        chk("stream_queue_empty", 64'(exp_q.size()), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        chk("stream_no_dup", 64'(extra), 64'd0);

        // Reset with beats in flight
        for (int i = 0; i < 3; i++) begin
            drive_beat(i + 5);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_sum", 64'(sum), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        chk("post_rst_flushed", 64'(extra), 64'd0);
        run_single("post_rst_beat", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        chk("post_rst_alone", 64'(extra), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
